rx_iq_buffer: RTL and testbench

RX_IQ_BUFFER -- requirements
Module: rx_iq_buffer

---
 rtl/rx_iq_buffer.sv | 136 +++++++++++++
 tb/tb_rx_iq_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_buffer.sv
// Purpose : FWFT FIFO buffering 4x24-bit RX I/Q sample sets between the decimator and the bus interface.
// Latency : a set pushed into an empty FIFO at edge E is visible on RX* after edge E+1; pop is edge-detected on IQ_RX_READ_CLK.
// Backpr. : none upstream; a push into a full FIFO is dropped and flagged (iq_overrun), a pop on empty is refused and flagged (iq_underrun).
//
// Ports:
//   clk_in, reset_n                      clock, asynchronous active-low reset
//   rx_iq_valid, RX{1,2}_{I,Q}_IN        push strobe and 24-bit signed sample set
//   IQ_RX_READ_REQ, IQ_RX_READ_CLK       bus read-request level and read strobe (rising edge pops)
//   flags_clear                          clears iq_overrun / iq_underrun
//   RX{1,2}_{I,Q}                        registered head-of-FIFO sample set (zeros when empty)
//   iq_empty, iq_full, iq_level          registered occupancy status
//   iq_overrun, iq_underrun              sticky error flags
module rx_iq_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                      clk_in,
   input  logic                      reset_n,
   input  logic                      rx_iq_valid,
   input  logic signed [23:0]        RX1_I_IN,
   input  logic signed [23:0]        RX1_Q_IN,
   input  logic signed [23:0]        RX2_I_IN,
   input  logic signed [23:0]        RX2_Q_IN,
   input  logic                      IQ_RX_READ_REQ,
   input  logic                      IQ_RX_READ_CLK,
   input  logic                      flags_clear,
   output logic signed [23:0]        RX1_I,
   output logic signed [23:0]        RX1_Q,
   output logic signed [23:0]        RX2_I,
   output logic signed [23:0]        RX2_Q,
   output logic                      iq_empty,
   output logic                      iq_full,
   output logic [$clog2(DEPTH):0]    iq_level,
   output logic                      iq_overrun,
   output logic                      iq_underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   if ((DEPTH < 4) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("rx_iq_buffer: DEPTH must be a power of two between 4 and 64");
   end

   logic [95:0]    mem [DEPTH];

   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic           empty_q, full_q;
   logic           ovr_q, ovr_d;
   logic           und_q, und_d;
   logic [95:0]    head_q, head_d;
   logic           clk_d_q;
   // Low while in reset and for the first edge after release, so the edge at
   // which reset deasserts can never honour a push or pop.
   logic           arm_q;

   logic           pop_req;
   logic           pop_ok;
   logic           pop_fail;
   logic           push_ok;
   logic           push_drop;

   always_comb begin
      pop_req   = IQ_RX_READ_CLK & ~clk_d_q & IQ_RX_READ_REQ & arm_q;
      pop_ok    = pop_req && (level_q != '0);
      pop_fail  = pop_req && (level_q == '0);
      // A full FIFO still accepts a push when a pop frees a slot on the same edge.
      push_ok   = rx_iq_valid && arm_q && ((level_q != FULL_LVL) || pop_ok);
      push_drop = rx_iq_valid && arm_q && !push_ok;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Set wins over a coincident clear.
      ovr_d = push_drop ? 1'b1 : (flags_clear ? 1'b0 : ovr_q);
      und_d = pop_fail  ? 1'b1 : (flags_clear ? 1'b0 : und_q);

      // Head register tracks the committed state one edge behind, which gives
      // the consumer a stable pre-pop value on the edge its strobe is seen.
      head_d = (level_q != '0) ? mem[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= {RX1_I_IN, RX1_Q_IN, RX2_I_IN, RX2_Q_IN};
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovr_q    <= 1'b0;
         und_q    <= 1'b0;
         head_q   <= '0;
         clk_d_q  <= 1'b0;
         arm_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= (level_d == '0);
         full_q   <= (level_d == FULL_LVL);
         ovr_q    <= ovr_d;
         und_q    <= und_d;
         head_q   <= head_d;
         clk_d_q  <= IQ_RX_READ_CLK;
         arm_q    <= 1'b1;
      end
   end

   assign {RX1_I, RX1_Q, RX2_I, RX2_Q} = head_q;
   assign iq_empty    = empty_q;
   assign iq_full     = full_q;
   assign iq_level    = level_q;
   assign iq_overrun  = ovr_q;
   assign iq_underrun = und_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Purpose : directed self-checking bench for rx_iq_buffer (DEPTH=16).
// Latency : inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpr. : n/a.
module tb_rx_iq_buffer;

   logic               clk_in = 1'b0;
   logic               reset_n;
   logic               rx_iq_valid = 1'b0;
   logic signed [23:0] RX1_I_IN = '0, RX1_Q_IN = '0, RX2_I_IN = '0, RX2_Q_IN = '0;
   logic               IQ_RX_READ_REQ = 1'b0;
   logic               IQ_RX_READ_CLK = 1'b0;
   logic               flags_clear = 1'b0;
   logic signed [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
   logic               iq_empty, iq_full, iq_overrun, iq_underrun;
   logic [4:0]         iq_level;

   int n_tests = 0;
   int n_fail  = 0;

   rx_iq_buffer #(.DEPTH(16)) dut (
      .clk_in(clk_in), .reset_n(reset_n), .rx_iq_valid(rx_iq_valid),
      .RX1_I_IN(RX1_I_IN), .RX1_Q_IN(RX1_Q_IN), .RX2_I_IN(RX2_I_IN), .RX2_Q_IN(RX2_Q_IN),
      .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .IQ_RX_READ_CLK(IQ_RX_READ_CLK), .flags_clear(flags_clear),
      .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
      .iq_empty(iq_empty), .iq_full(iq_full), .iq_level(iq_level),
      .iq_overrun(iq_overrun), .iq_underrun(iq_underrun)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [95:0] outs();
      return {RX1_I, RX1_Q, RX2_I, RX2_Q};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive_set(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
      RX1_I_IN = a; RX1_Q_IN = b; RX2_I_IN = c; RX2_Q_IN = d;
   endtask

   task automatic push_set(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
      drive_set(a, b, c, d);
      rx_iq_valid = 1'b1;
      tick();
      rx_iq_valid = 1'b0;
   endtask

   // Pop edge followed by an idle edge, so RX* show the new head on return.
   task automatic pop_one();
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      tick();
      IQ_RX_READ_CLK = 1'b0;
      IQ_RX_READ_REQ = 1'b0;
      tick();
   endtask

   task automatic clear_flags();
      flags_clear = 1'b1;
      tick();
      flags_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #23;
      n_tests++; if (outs() !== 96'h0) begin n_fail++; $display("FAIL reset_rx: got %h want 0", outs()); end
      n_tests++; if (iq_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", iq_empty); end
      n_tests++; if (iq_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", iq_full); end
      n_tests++; if (iq_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", iq_level); end
      n_tests++; if ({iq_overrun, iq_underrun} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {iq_overrun, iq_underrun}); end
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_single_push();
      push_set(24'h123456, 24'hFEDCBA, 24'h000001, 24'h800000);
      n_tests++; if (iq_level !== 5'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", iq_level); end
      n_tests++; if (iq_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", iq_empty); end
      n_tests++; if (outs() !== 96'h0) begin n_fail++; $display("FAIL single_early: got %h want 0", outs()); end
      tick();
      n_tests++; if (outs() !== 96'h123456_FEDCBA_000001_800000) begin n_fail++; $display("FAIL single_data: got %h want 123456fedcba000001800000", outs()); end
      pop_one();
      n_tests++; if (iq_level !== 5'd0 || iq_empty !== 1'b1) begin n_fail++; $display("FAIL single_drain: got level %0d empty %b want 0 1", iq_level, iq_empty); end
      n_tests++; if (outs() !== 96'h0 || iq_underrun !== 1'b0) begin n_fail++; $display("FAIL single_after: got %h und %b want 0 0", outs(), iq_underrun); end
   endtask

   task automatic test_fill_overrun();
      for (int k = 1; k <= 16; k++) push_set(24'(k), 24'(k + 100), 24'(k + 200), 24'(k + 300));
      n_tests++; if (iq_level !== 5'd16 || iq_full !== 1'b1 || iq_overrun !== 1'b0) begin n_fail++; $display("FAIL fill_16: got level %0d full %b ovr %b want 16 1 0", iq_level, iq_full, iq_overrun); end
      push_set(24'd17, 24'd117, 24'd217, 24'd317);
      n_tests++; if (iq_level !== 5'd16 || iq_full !== 1'b1) begin n_fail++; $display("FAIL fill_17_level: got level %0d full %b want 16 1", iq_level, iq_full); end
      n_tests++; if (iq_overrun !== 1'b1) begin n_fail++; $display("FAIL fill_overrun: got %b want 1", iq_overrun); end
      for (int k = 1; k <= 16; k++) begin
         n_tests++;
         if (RX1_I !== 24'(k) || RX2_Q !== 24'(k + 300)) begin
            n_fail++; $display("FAIL fill_pop_%0d: got %h/%h want %h/%h", k, RX1_I, RX2_Q, 24'(k), 24'(k + 300));
         end
         pop_one();
      end
      n_tests++; if (iq_level !== 5'd0 || iq_empty !== 1'b1 || outs() !== 96'h0) begin n_fail++; $display("FAIL fill_17_absent: got level %0d empty %b rx %h want 0 1 0", iq_level, iq_empty, outs()); end
      clear_flags();
      n_tests++; if (iq_overrun !== 1'b0 || iq_underrun !== 1'b0) begin n_fail++; $display("FAIL fill_clear: got ovr %b und %b want 0 0", iq_overrun, iq_underrun); end
   endtask

   task automatic test_level_hold();
      push_set(24'h31, 24'h0, 24'h0, 24'h0);
      push_set(24'h32, 24'h0, 24'h0, 24'h0);
      push_set(24'h33, 24'h0, 24'h0, 24'h0);
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      repeat (5) tick();
      IQ_RX_READ_CLK = 1'b0;
      IQ_RX_READ_REQ = 1'b0;
      tick();
      n_tests++; if (iq_level !== 5'd2) begin n_fail++; $display("FAIL hold_level: got %0d want 2", iq_level); end
      n_tests++; if (RX1_I !== 24'h32) begin n_fail++; $display("FAIL hold_head: got %h want 000032", RX1_I); end
      pop_one();
      pop_one();
      n_tests++; if (iq_level !== 5'd0 || iq_underrun !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got level %0d und %b want 0 0", iq_level, iq_underrun); end
   endtask

   task automatic test_underrun();
      pop_one();
      n_tests++; if (iq_underrun !== 1'b1) begin n_fail++; $display("FAIL und_set: got %b want 1", iq_underrun); end
      n_tests++; if (outs() !== 96'h0 || iq_level !== 5'd0) begin n_fail++; $display("FAIL und_state: got rx %h level %0d want 0 0", outs(), iq_level); end
      clear_flags();
      n_tests++; if (iq_underrun !== 1'b0) begin n_fail++; $display("FAIL und_clear: got %b want 0", iq_underrun); end
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      flags_clear    = 1'b1;
      tick();
      IQ_RX_READ_CLK = 1'b0;
      IQ_RX_READ_REQ = 1'b0;
      flags_clear    = 1'b0;
      tick();
      n_tests++; if (iq_underrun !== 1'b1) begin n_fail++; $display("FAIL und_set_wins: got %b want 1", iq_underrun); end
      clear_flags();
      n_tests++; if (iq_underrun !== 1'b0) begin n_fail++; $display("FAIL und_clear2: got %b want 0", iq_underrun); end
   endtask

   task automatic test_empty_push_pop();
      drive_set(24'h51, 24'h0, 24'h0, 24'h0);
      rx_iq_valid    = 1'b1;
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      tick();
      rx_iq_valid    = 1'b0;
      IQ_RX_READ_CLK = 1'b0;
      IQ_RX_READ_REQ = 1'b0;
      tick();
      n_tests++; if (iq_level !== 5'd1 || iq_underrun !== 1'b1) begin n_fail++; $display("FAIL epp_state: got level %0d und %b want 1 1", iq_level, iq_underrun); end
      n_tests++; if (RX1_I !== 24'h51) begin n_fail++; $display("FAIL epp_head: got %h want 000051", RX1_I); end
      clear_flags();
      push_set(24'h52, 24'h0, 24'h0, 24'h0);
      drive_set(24'h53, 24'h0, 24'h0, 24'h0);
      rx_iq_valid    = 1'b1;
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      tick();
      rx_iq_valid    = 1'b0;
      IQ_RX_READ_CLK = 1'b0;
      IQ_RX_READ_REQ = 1'b0;
      tick();
      n_tests++; if (iq_level !== 5'd2 || RX1_I !== 24'h52 || iq_underrun !== 1'b0) begin n_fail++; $display("FAIL mid_push_pop: got level %0d head %h und %b want 2 000052 0", iq_level, RX1_I, iq_underrun); end
      pop_one();
      n_tests++; if (RX1_I !== 24'h53) begin n_fail++; $display("FAIL mid_tail: got %h want 000053", RX1_I); end
      pop_one();
      n_tests++; if (iq_level !== 5'd0) begin n_fail++; $display("FAIL mid_drain: got %0d want 0", iq_level); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 16; k++) push_set(24'(8'h40 + k), 24'h0, 24'h0, 24'h0);
      drive_set(24'hAA, 24'h0, 24'h0, 24'h0);
      rx_iq_valid    = 1'b1;
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      tick();
      rx_iq_valid    = 1'b0;
      IQ_RX_READ_CLK = 1'b0;
      IQ_RX_READ_REQ = 1'b0;
      tick();
      n_tests++; if (iq_level !== 5'd16 || iq_full !== 1'b1 || iq_overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_state: got level %0d full %b ovr %b want 16 1 0", iq_level, iq_full, iq_overrun); end
      n_tests++; if (RX1_I !== 24'h41) begin n_fail++; $display("FAIL fpp_head: got %h want 000041", RX1_I); end
      repeat (15) pop_one();
      n_tests++; if (RX1_I !== 24'hAA || iq_level !== 5'd1) begin n_fail++; $display("FAIL fpp_tail: got head %h level %0d want 0000aa 1", RX1_I, iq_level); end
      pop_one();
      n_tests++; if (iq_level !== 5'd0 || iq_empty !== 1'b1) begin n_fail++; $display("FAIL fpp_drain: got level %0d empty %b want 0 1", iq_level, iq_empty); end
   endtask

   task automatic test_reset_mid();
      for (int k = 1; k <= 5; k++) push_set(24'(8'h60 + k), 24'h0, 24'h0, 24'h0);
      n_tests++; if (iq_level !== 5'd5) begin n_fail++; $display("FAIL rmid_pre: got %0d want 5", iq_level); end
      #3;
      reset_n = 1'b0;
      #1;
      n_tests++; if (iq_level !== 5'd0 || iq_empty !== 1'b1 || iq_full !== 1'b0) begin n_fail++; $display("FAIL rmid_status: got level %0d empty %b full %b want 0 1 0", iq_level, iq_empty, iq_full); end
      n_tests++; if (outs() !== 96'h0 || iq_overrun !== 1'b0 || iq_underrun !== 1'b0) begin n_fail++; $display("FAIL rmid_outs: got rx %h ovr %b und %b want 0 0 0", outs(), iq_overrun, iq_underrun); end
      tick();
      tick();
      #2;
      reset_n = 1'b1;
      tick();
      tick();
      push_set(24'd7, 24'h0, 24'h0, 24'h0);
      tick();
      n_tests++; if (RX1_I !== 24'd7 || iq_level !== 5'd1) begin n_fail++; $display("FAIL rmid_push: got head %h level %0d want 000007 1", RX1_I, iq_level); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_overrun();
      test_level_hold();
      test_underrun();
      test_empty_push_pop();
      test_full_push_pop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
